// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
// Bundles the signals between the PLL lock supervisor and its surroundings.
//   pll_locked    PLL lock indication, asynchronous to the supervisor clock
//   pll_rst       reset to the PLL
//   domain_reset  per-domain reset requests, active-high
//   ready         high while every domain is out of reset
//   lost_lock     one-cycle pulse on loss of lock after release has begun
//   relock_count  saturating count of PLL restarts
// Modports:
//   slave   the supervisor itself (consumes pll_locked, drives the rest)
//   master  the PLL / core side (drives pll_locked, observes the rest)
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if #(
  parameter int NUM_RESETS = 3
);
  logic                  pll_locked;
  logic                  pll_rst;
  logic [NUM_RESETS-1:0] domain_reset;
  logic                  ready;
  logic                  lost_lock;
  logic [7:0]            relock_count;

  modport master (
    output pll_locked,
    input  pll_rst, domain_reset, ready, lost_lock, relock_count
  );

  modport slave (
    input  pll_locked,
    output pll_rst, domain_reset, ready, lost_lock, relock_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// Runs on the PLL reference clock. Holds the PLL in reset for a fixed time,
// waits (with timeout) for lock, requires lock to be stable, then releases
// the domain resets one by one. Any loss of lock after release has started
// re-asserts every domain reset and restarts the PLL.
// Ports:
//   clk     reference clock, sole clock
//   reset   synchronous, active-high
//   pll_if  slave modport of pll_lock_supervisor_if (see that file)
// All interface outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int NUM_RESETS     = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RELOCK_TIMEOUT = 65536,
  parameter int RELEASE_GAP    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pll_lock_supervisor_if.slave pll_if
);

  // One counter serves every state; it restarts on each state entry, so it
  // only has to span the largest of the interval parameters.
  localparam int CNT_MAX_A = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int CNT_MAX_B = (RELOCK_TIMEOUT > RELEASE_GAP) ? RELOCK_TIMEOUT : RELEASE_GAP;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RELOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);
  localparam logic [NUM_RESETS-1:0] ALL_ONES = {NUM_RESETS{1'b1}};

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RELEASE,
    S_RUN
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  meta_q;
  logic                  lk_q;
  logic                  pll_rst_q;
  logic [NUM_RESETS-1:0] domain_reset_q;
  logic                  ready_q;
  logic                  lost_lock_q;
  logic [7:0]            relock_q;
  logic [7:0]            relock_inc;

  assign relock_inc = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

  // NOTE: every register below is written with <= so all flops sample the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_PLL_RESET;
      cnt_q          <= '0;
      meta_q         <= 1'b0;
      lk_q           <= 1'b0;
      pll_rst_q      <= 1'b1;
      domain_reset_q <= ALL_ONES;
      ready_q        <= 1'b0;
      lost_lock_q    <= 1'b0;
      relock_q       <= 8'd0;
    end else begin
      // Two-flop synchroniser; only lk_q is ever looked at by the FSM.
      meta_q      <= pll_if.pll_locked;
      lk_q        <= meta_q;
      lost_lock_q <= 1'b0;
      cnt_q       <= cnt_q + CNT_W'(1);

      unique case (state_q)
        S_PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end
        end

        S_WAIT_LOCK: begin
          if (lk_q) begin
            state_q <= S_STABILIZE;
            cnt_q   <= '0;
          end else if (cnt_q == TMO_LAST) begin
            state_q   <= S_PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            relock_q  <= relock_inc;
          end
        end

        S_STABILIZE: begin
          // A single dropped sample sends us back to wait with a fresh timeout.
          if (!lk_q) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STB_LAST) begin
            state_q        <= S_RELEASE;
            cnt_q          <= '0;
            domain_reset_q <= ALL_ONES << 1;
          end
        end

        S_RELEASE, S_RUN: begin
          // Loss of lock outranks any release step or the RUN entry.
          if (!lk_q) begin
            state_q        <= S_PLL_RESET;
            cnt_q          <= '0;
            pll_rst_q      <= 1'b1;
            domain_reset_q <= ALL_ONES;
            ready_q        <= 1'b0;
            lost_lock_q    <= 1'b1;
            relock_q       <= relock_inc;
          end else if (state_q == S_RELEASE && cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (domain_reset_q == '0) begin
              state_q <= S_RUN;
              ready_q <= 1'b1;
            end else begin
              // Shifting in zeros from the bottom clears indices in ascending order.
              domain_reset_q <= domain_reset_q << 1;
            end
          end
        end

        default: begin
          state_q        <= S_PLL_RESET;
          cnt_q          <= '0;
          pll_rst_q      <= 1'b1;
          domain_reset_q <= ALL_ONES;
          ready_q        <= 1'b0;
        end
      endcase
    end
  end

  assign pll_if.pll_rst      = pll_rst_q;
  assign pll_if.domain_reset = domain_reset_q;
  assign pll_if.ready        = ready_q;
  assign pll_if.lost_lock    = lost_lock_q;
  assign pll_if.relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with short intervals
// (PLL_RST_CYCLES=4, STABLE_CYCLES=8, RELOCK_TIMEOUT=20, RELEASE_GAP=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Edge numbers in each scenario count rising edges after the last reference
// point (reset release or the last observation of the previous scenario).
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int NR = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic seen;

  pll_lock_supervisor_if #(.NUM_RESETS(NR)) bus ();

  pll_lock_supervisor #(
    .NUM_RESETS    (NR),
    .PLL_RST_CYCLES(4),
    .STABLE_CYCLES (8),
    .RELOCK_TIMEOUT(20),
    .RELEASE_GAP   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pll_if(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.pll_locked = 1'b0;

    // ---------------- reset state ----------------
    do_reset(2);
    check("rst_pll_rst",   32'(bus.pll_rst),      32'd1);
    check("rst_domain",    32'(bus.domain_reset), 32'b111);
    check("rst_ready",     32'(bus.ready),        32'd0);
    check("rst_lost_lock", 32'(bus.lost_lock),    32'd0);
    check("rst_relock",    32'(bus.relock_count), 32'd0);

    // ---------------- 1: clean bring-up ----------------
    // lock visible to FSM at edge 12 -> STABILIZE, RELEASE at 20, RUN at 26
    for (int n = 1; n <= 26; n++) begin
      tick();
      case (n)
        1, 3:   check($sformatf("t1_pll_rst_e%0d", n), 32'(bus.pll_rst), 32'd1);
        4:      check("t1_pll_rst_e4", 32'(bus.pll_rst), 32'd0);
        9:      bus.pll_locked = 1'b1;
        19:     check("t1_dom_e19", 32'(bus.domain_reset), 32'b111);
        20, 21: check($sformatf("t1_dom_e%0d", n), 32'(bus.domain_reset), 32'b110);
        22:     check("t1_dom_e22", 32'(bus.domain_reset), 32'b100);
        24:     check("t1_dom_e24", 32'(bus.domain_reset), 32'b000);
        25:     check("t1_ready_e25", 32'(bus.ready), 32'd0);
        26: begin
          check("t1_ready_e26",  32'(bus.ready),        32'd1);
          check("t1_relock_e26", 32'(bus.relock_count), 32'd0);
        end
        default: ;
      endcase
    end

    // ---------------- 4: loss in RUN ----------------
    // drop now; FSM sees it at edge 3; relock re-released, RUN at edge 22
    bus.pll_locked = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      case (k)
        2: begin
          check("t4_ready_e2", 32'(bus.ready),     32'd1);
          check("t4_lost_e2",  32'(bus.lost_lock), 32'd0);
        end
        3: begin
          check("t4_dom_e3",    32'(bus.domain_reset), 32'b111);
          check("t4_ready_e3",  32'(bus.ready),        32'd0);
          check("t4_lost_e3",   32'(bus.lost_lock),    32'd1);
          check("t4_relock_e3", 32'(bus.relock_count), 32'd1);
          check("t4_rst_e3",    32'(bus.pll_rst),      32'd1);
          bus.pll_locked = 1'b1;
        end
        4:  check("t4_lost_e4",  32'(bus.lost_lock), 32'd0);
        6:  check("t4_rst_e6",   32'(bus.pll_rst),   32'd1);
        7:  check("t4_rst_e7",   32'(bus.pll_rst),   32'd0);
        16: check("t4_dom_e16",  32'(bus.domain_reset), 32'b110);
        21: check("t4_ready_e21", 32'(bus.ready), 32'd0);
        22: begin
          check("t4_ready_e22",  32'(bus.ready),        32'd1);
          check("t4_dom_e22",    32'(bus.domain_reset), 32'b000);
          check("t4_relock_e22", 32'(bus.relock_count), 32'd1);
        end
        default: ;
      endcase
    end

    // ---------------- 5: loss mid-RELEASE ----------------
    // loss at edge 3 (relock 2), RELEASE entry at 16, second loss seen at 18,
    // which is also a release step: loss must win, nothing further clears
    bus.pll_locked = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      case (k)
        3: begin
          check("t5_relock_e3", 32'(bus.relock_count), 32'd2);
          bus.pll_locked = 1'b1;
        end
        15: bus.pll_locked = 1'b0;
        16, 17: check($sformatf("t5_dom_e%0d", k), 32'(bus.domain_reset), 32'b110);
        18: begin
          check("t5_dom_e18",    32'(bus.domain_reset), 32'b111);
          check("t5_lost_e18",   32'(bus.lost_lock),    32'd1);
          check("t5_relock_e18", 32'(bus.relock_count), 32'd3);
          check("t5_rst_e18",    32'(bus.pll_rst),      32'd1);
        end
        19: check("t5_lost_e19", 32'(bus.lost_lock), 32'd0);
        21: check("t5_rst_e21",  32'(bus.pll_rst),   32'd1);
        22: check("t5_rst_e22",  32'(bus.pll_rst),   32'd0);
        default: ;
      endcase
    end

    // ---------------- 3: glitch during STABILIZE ----------------
    // STABILIZE at 7, glitch seen at 12 -> WAIT_LOCK, back at 13, RELEASE at 21
    bus.pll_locked = 1'b0;
    do_reset(1);
    seen = 1'b0;
    for (int n = 1; n <= 27; n++) begin
      tick();
      if (n >= 4 && bus.pll_rst) seen = 1'b1;
      case (n)
        4:  bus.pll_locked = 1'b1;
        9:  bus.pll_locked = 1'b0;
        10: bus.pll_locked = 1'b1;
        20: check("t3_dom_e20", 32'(bus.domain_reset), 32'b111);
        21: check("t3_dom_e21", 32'(bus.domain_reset), 32'b110);
        26: check("t3_ready_e26", 32'(bus.ready), 32'd0);
        27: begin
          check("t3_ready_e27",  32'(bus.ready),        32'd1);
          check("t3_relock_e27", 32'(bus.relock_count), 32'd0);
        end
        default: ;
      endcase
    end
    check("t3_no_pll_rst", 32'(seen), 32'd0);

    // ---------------- 2 + 6: lock timeouts, saturation ----------------
    // timeout m lands on edge 24*m; pll_rst high on edges 24m..24m+3
    bus.pll_locked = 1'b0;
    do_reset(1);
    seen = 1'b0;
    for (int n = 1; n <= 6245; n++) begin
      tick();
      if (bus.ready) seen = 1'b1;
      case (n)
        23: begin
          check("t2_rst_e23",    32'(bus.pll_rst),      32'd0);
          check("t2_relock_e23", 32'(bus.relock_count), 32'd0);
        end
        24: begin
          check("t2_rst_e24",    32'(bus.pll_rst),      32'd1);
          check("t2_relock_e24", 32'(bus.relock_count), 32'd1);
        end
        27:   check("t2_rst_e27",    32'(bus.pll_rst),      32'd1);
        28:   check("t2_rst_e28",    32'(bus.pll_rst),      32'd0);
        47:   check("t2_relock_e47", 32'(bus.relock_count), 32'd1);
        48: begin
          check("t2_rst_e48",    32'(bus.pll_rst),      32'd1);
          check("t2_relock_e48", 32'(bus.relock_count), 32'd2);
        end
        72:   check("t2_relock_e72",   32'(bus.relock_count), 32'd3);
        6119: check("t6_relock_e6119", 32'(bus.relock_count), 32'd254);
        6120: check("t6_relock_e6120", 32'(bus.relock_count), 32'd255);
        6240: check("t6_relock_e6240", 32'(bus.relock_count), 32'd255);
        6245: check("t6_rst_e6245",    32'(bus.pll_rst),      32'd0);
        default: ;
      endcase
    end
    check("t2_ready_never", 32'(seen), 32'd0);

    do_reset(1);
    check("t6_relock_after_rst", 32'(bus.relock_count), 32'd0);
    check("t6_rst_after_rst",    32'(bus.pll_rst),      32'd1);
    check("t6_dom_after_rst",    32'(bus.domain_reset), 32'b111);
    check("t6_ready_after_rst",  32'(bus.ready),        32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
